// File: rtl/pwm_dc_ramp_if.sv
// Control/status bundle between board inputs, the ramp sequencer and the PWM stage.
// master drives run controls; slave is the sequencer.
interface pwm_dc_ramp_if #(
    parameter int DC_W = 10
);
    logic            i_en;
    logic            i_hold;
    logic [3:0]      i_step;
    logic [DC_W-1:0] o_dc;
    logic            o_active;
    logic            o_tick;
    logic            o_cycle_done;

    modport master (
        output i_en, i_hold, i_step,
        input  o_dc, o_active, o_tick, o_cycle_done
    );

    modport slave (
        input  i_en, i_hold, i_step,
        output o_dc, o_active, o_tick, o_cycle_done
    );
endinterface

// File: rtl/pwm_dc_ramp.sv
// Triangle-wave duty-cycle sequencer ("breathing" LED) feeding simple_pwm.
// Ramps 0 -> MAX, dwells, ramps back to 0, dwells, repeats; one step per prescaler tick.
module pwm_dc_ramp #(
    parameter int DC_W  = 10,
    parameter int DIV   = 48828,
    parameter int DWELL = 64
) (
    input logic        i_clk,
    input logic        i_rst,
    pwm_dc_ramp_if.slave bus
);
    localparam int PW = $clog2(DIV);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [PW-1:0]   P_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0]   D_LAST = DW'(DWELL - 1);
    localparam logic [DC_W-1:0] MAX    = '1;

    typedef enum logic [2:0] {IDLE, UP, TOP, DOWN, BOT} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [DC_W-1:0] dc_q, dc_d;
    logic            tick_q, tick_d;
    logic            done_q, done_d;
    logic            active_q, active_d;

    logic [3:0]      step;
    logic [DC_W:0]   s_ext;
    logic [DC_W:0]   sum;

    // Sum and compare carry one extra bit so clamping never sees a wrapped value.
    assign step  = (bus.i_step == 4'd0) ? 4'd1 : bus.i_step;
    assign s_ext = (DC_W+1)'(step);
    assign sum   = {1'b0, dc_q} + s_ext;

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        dcnt_d  = dcnt_q;
        dc_d    = dc_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        if (!bus.i_en) begin
            state_d = IDLE;
            pcnt_d  = '0;
            dcnt_d  = '0;
            dc_d    = '0;
        end else if (state_q == IDLE) begin
            state_d = UP;
            pcnt_d  = '0;
            dcnt_d  = '0;
            dc_d    = '0;
        end else if (!bus.i_hold) begin
            if (pcnt_q != P_LAST) begin
                pcnt_d = pcnt_q + 1'b1;
            end else begin
                pcnt_d = '0;
                tick_d = 1'b1;
                unique case (state_q)
                    UP: begin
                        if (sum >= {1'b0, MAX}) begin
                            dc_d    = MAX;
                            state_d = TOP;
                            dcnt_d  = '0;
                        end else begin
                            dc_d = sum[DC_W-1:0];
                        end
                    end
                    TOP: begin
                        if (dcnt_q == D_LAST) begin
                            state_d = DOWN;
                            dcnt_d  = '0;
                        end else begin
                            dcnt_d = dcnt_q + 1'b1;
                        end
                    end
                    DOWN: begin
                        if ({1'b0, dc_q} <= s_ext) begin
                            dc_d    = '0;
                            state_d = BOT;
                            dcnt_d  = '0;
                        end else begin
                            dc_d = dc_q - s_ext[DC_W-1:0];
                        end
                    end
                    BOT: begin
                        if (dcnt_q == D_LAST) begin
                            state_d = UP;
                            dcnt_d  = '0;
                            done_d  = 1'b1;
                        end else begin
                            dcnt_d = dcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            pcnt_q   <= '0;
            dcnt_q   <= '0;
            dc_q     <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            dcnt_q   <= dcnt_d;
            dc_q     <= dc_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            active_q <= active_d;
        end
    end

    assign bus.o_dc         = dc_q;
    assign bus.o_active     = active_q;
    assign bus.o_tick       = tick_q;
    assign bus.o_cycle_done = done_q;
endmodule

// File: tb/tb_pwm_dc_ramp.sv
// Directed bench for pwm_dc_ramp with DC_W=4, DIV=4, DWELL=2.
module tb_pwm_dc_ramp;
    localparam int DC_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_dc_ramp_if #(.DC_W(DC_W)) bus ();

    pwm_dc_ramp #(
        .DC_W (DC_W),
        .DIV  (4),
        .DWELL(2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    typedef struct {
        bit       restart;
        bit [3:0] step;
        bit [3:0] exp_dc;
        bit       exp_done;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;
    int   tick_cnt = 0;
    int   breaths[$];

    // Ticks per completed breath, cleared whenever the sequencer is idle.
    always @(negedge clk) begin
        if (!bus.o_active) begin
            tick_cnt <= 0;
        end else if (bus.o_tick) begin
            if (bus.o_cycle_done) begin
                breaths.push_back(tick_cnt + 1);
                tick_cnt <= 0;
            end else begin
                tick_cnt <= tick_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input int st, input int dc, input bit dn);
        vec_t v;
        v.restart  = r;
        v.step     = 4'(st);
        v.exp_dc   = 4'(dc);
        v.exp_done = dn;
        tbl.push_back(v);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_tick && n < 40);
        if (!bus.o_tick) check("tick_timeout", 0, 1);
    endtask

    task automatic restart();
        bus.i_en = 1'b0;
        @(negedge clk);
        bus.i_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit bad;

        add(1, 1, 1, 0);
        for (int t = 2; t <= 15; t++) add(0, 1, t, 0);
        add(0, 1, 15, 0);
        add(0, 1, 15, 0);
        for (int t = 18; t <= 32; t++) add(0, 1, 32 - t, 0);
        add(0, 1, 0, 0);
        add(0, 1, 0, 1);
        add(0, 1, 1, 0);
        add(1, 6, 6, 0);
        add(0, 6, 12, 0);
        add(0, 6, 15, 0);
        add(0, 6, 15, 0);
        add(0, 6, 15, 0);
        add(0, 6, 9, 0);
        add(0, 6, 3, 0);
        add(0, 6, 0, 0);
        add(0, 6, 0, 0);
        add(0, 6, 0, 1);
        add(0, 6, 6, 0);
        add(1, 0, 1, 0);
        add(0, 0, 2, 0);
        add(0, 0, 3, 0);
        add(1, 1, 1, 0);
        add(0, 1, 2, 0);
        add(0, 1, 3, 0);
        add(0, 4, 7, 0);
        add(0, 4, 11, 0);

        bus.i_en   = 1'b0;
        bus.i_hold = 1'b0;
        bus.i_step = 4'd1;
        repeat (2) @(negedge clk);
        check("rst_dc", 32'(bus.o_dc), 0);
        check("rst_active", 32'(bus.o_active), 0);
        check("rst_tick", 32'(bus.o_tick), 0);
        check("rst_done", 32'(bus.o_cycle_done), 0);

        rst = 1'b0;
        bus.i_en = 1'b1;
        wait_tick(n);
        check("pre_rst_dc", 32'(bus.o_dc), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_dc", 32'(bus.o_dc), 0);
        check("async_rst_active", 32'(bus.o_active), 0);
        check("async_rst_tick", 32'(bus.o_tick), 0);
        @(negedge clk);
        bus.i_en = 1'b0;
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.o_dc != 0 || bus.o_active) bad = 1;
        end
        check("idle_100", 32'(bad), 0);

        foreach (tbl[i]) begin
            if (tbl[i].restart) restart();
            bus.i_step = tbl[i].step;
            wait_tick(n);
            check($sformatf("v%0d_dc", i), 32'(bus.o_dc), 32'(tbl[i].exp_dc));
            check($sformatf("v%0d_done", i), 32'(bus.o_cycle_done),
                  32'(tbl[i].exp_done));
            check($sformatf("v%0d_gap", i), n, tbl[i].restart ? 5 : 4);
            check($sformatf("v%0d_active", i), 32'(bus.o_active), 1);
        end

        check("breath_count", breaths.size() >= 2, 1);
        if (breaths.size() >= 2) begin
            check("breath_ticks_s1", breaths[0], 34);
            check("breath_ticks_s6", breaths[1], 10);
        end

        restart();
        bus.i_step = 4'd1;
        repeat (5) wait_tick(n);
        check("hold_start_dc", 32'(bus.o_dc), 5);
        bus.i_hold = 1'b1;
        bad = 0;
        repeat (7) begin
            @(negedge clk);
            if (bus.o_tick || bus.o_dc != 5) bad = 1;
        end
        bus.i_hold = 1'b0;
        check("hold_freeze", 32'(bad), 0);
        wait_tick(n);
        check("hold_gap", n, 4);
        check("hold_next_dc", 32'(bus.o_dc), 6);

        restart();
        bus.i_step = 4'd6;
        repeat (6) wait_tick(n);
        check("dis_start_dc", 32'(bus.o_dc), 9);
        repeat (3) @(negedge clk);
        bus.i_en = 1'b0;
        @(negedge clk);
        check("dis_dc", 32'(bus.o_dc), 0);
        check("dis_active", 32'(bus.o_active), 0);
        check("dis_tick", 32'(bus.o_tick), 0);
        check("dis_done", 32'(bus.o_cycle_done), 0);
        bus.i_step = 4'd1;
        bus.i_en = 1'b1;
        wait_tick(n);
        check("reen_gap", n, 5);
        check("reen_dc", 32'(bus.o_dc), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
